i2c_target_regif: RTL

I2C target (slave) that answers the host-side I2C master on `hif_scl`/`hif_sda` and converts bus transactions into single-cycle register accesses in the `xtal_clk` domain. It runs from `xtal_clk` alone and oversamples the bus lines. It sits in `digtop` between the pad-level SCL/SDA and the register file that fronts the OTP controller. It also reports bus idleness on `hif_idle_out`.

---
 rtl/i2c_tgt_pkg.sv | 19 +
 rtl/i2c_target_regif_bus_cond.sv | 62 ++++++
 rtl/i2c_target_regif.sv | 139 +++++++++++++
 3 files changed

// File: rtl/i2c_tgt_pkg.sv
// i2c_tgt_pkg: shared constants and FSM state type for the I2C target register interface
package i2c_tgt_pkg;
  localparam int I2C_BYTE_W = 8;
  localparam int RW_BIT = 0;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_e;
endpackage

// File: rtl/i2c_target_regif_bus_cond.sv
// i2c_bus_cond: synchronize SCL/SDA, optionally deglitch them, and derive one-cycle bus events
// clk_i, rst_ni       : clock and asynchronous active-low reset
// scl_i, sda_i        : raw asynchronous bus pins
// sda_o               : conditioned SDA level used for bit sampling
// scl_rise_o/scl_fall_o/start_o/stop_o : one-cycle event pulses
// I2C_TGT_GLITCH_FILTER_EN : when defined, a line only changes after 3 agreeing samples
module i2c_bus_cond (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  logic [1:0] scl_sync_q, sda_sync_q;
  logic scl_prev_q, sda_prev_q;
  logic scl_f, sda_f;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
    end
  end
`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic scl_flt_q, sda_flt_q;
  // the two history samples plus the current synchronizer output must all agree
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_flt_q <= 1'b1;
      sda_flt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      if (scl_hist_q == {2{scl_sync_q[1]}}) scl_flt_q <= scl_sync_q[1];
      if (sda_hist_q == {2{sda_sync_q[1]}}) sda_flt_q <= sda_sync_q[1];
    end
  end
  assign scl_f = scl_flt_q;
  assign sda_f = sda_flt_q;
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif
  assign sda_o = sda_f;
  assign scl_rise_o = scl_f & ~scl_prev_q;
  assign scl_fall_o = ~scl_f & scl_prev_q;
  assign start_o = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop_o = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
endmodule

// File: rtl/i2c_target_regif.sv
// i2c_target_regif: I2C target turning bus transfers into single-cycle register accesses
// xtal_clk, por_rst_n : clock and asynchronous active-low reset
// hif_scl, hif_sda    : raw bus pins; sda_oe pulls SDA low when 1
// reg_addr/reg_wdata/reg_wr_en/reg_rd_en/reg_rdata : register file port
// hif_idle_out        : 1 while no transaction is open
// I2C_TGT_GLITCH_FILTER_EN : enables the bus glitch filter in i2c_bus_cond
module i2c_target_regif
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic                  xtal_clk,
  input  logic                  por_rst_n,
  input  logic                  hif_scl,
  input  logic                  hif_sda,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] reg_addr,
  output logic [I2C_BYTE_W-1:0] reg_wdata,
  output logic                  reg_wr_en,
  output logic                  reg_rd_en,
  input  logic [I2C_BYTE_W-1:0] reg_rdata,
  output logic                  hif_idle_out
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d, addr_q, addr_d, wdata_q, wdata_d, byte_in;
  logic wr_en_q, wr_en_d, sda_oe_q, sda_oe_d, idle_q, idle_d;
  logic sda_lvl, scl_rise, scl_fall, start, stop, rd_load;
  i2c_bus_cond u_bus_cond (
    .clk_i      (xtal_clk),
    .rst_ni     (por_rst_n),
    .scl_i      (hif_scl),
    .sda_i      (hif_sda),
    .sda_o      (sda_lvl),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start),
    .stop_o     (stop)
  );
  assign byte_in = {shift_q[I2C_BYTE_W-2:0], sda_lvl};
  // read data is fetched on the fall that ends an ACK: leaving ADDR_ACK for a read, or first fall in RDATA
  assign rd_load = scl_fall & ~start & ~stop &
                   ((state_q == ST_ADDR_ACK & sda_oe_q & shift_q[RW_BIT]) | (state_q == ST_RDATA & cnt_q == 4'd0));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    shift_d = shift_q;
    addr_d = wr_en_q ? addr_q + 8'd1 : addr_q;
    wdata_d = wdata_q;
    wr_en_d = 1'b0;
    sda_oe_d = sda_oe_q;
    idle_d = idle_q;
    reg_rd_en = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      sda_oe_d = 1'b0;
      idle_d = 1'b1;
    end else if (start) begin
      state_d = ST_ADDR;
      cnt_d = 4'd0;
      sda_oe_d = 1'b0;
      idle_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'(I2C_BYTE_W - 1)) begin
            cnt_d = 4'd0;
            if (state_q == ST_ADDR) state_d = byte_in[7:1] == DEV_ADDR ? ST_ADDR_ACK : ST_IGNORE;
            if (state_q == ST_PTR) begin
              addr_d = byte_in;
              state_d = ST_PTR_ACK;
            end
            if (state_q == ST_WDATA) begin
              wr_en_d = 1'b1;
              wdata_d = byte_in;
              state_d = ST_WDATA_ACK;
            end
          end
        end
        // first fall starts driving the ACK, second fall releases it and moves on
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
          sda_oe_d = ~sda_oe_q;
          if (sda_oe_q)
            state_d = state_q != ST_ADDR_ACK ? ST_WDATA : shift_q[RW_BIT] ? ST_RDATA : ST_PTR;
        end
        ST_RDATA: if (scl_fall && cnt_q != 4'd0) begin
          if (cnt_q == 4'(I2C_BYTE_W)) begin
            sda_oe_d = 1'b0;
            cnt_d = 4'd0;
            state_d = ST_RD_ACK;
          end else begin
            sda_oe_d = ~shift_q[I2C_BYTE_W-2];
            shift_d = {shift_q[I2C_BYTE_W-2:0], 1'b0};
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_RD_ACK: if (scl_rise) begin
          state_d = sda_lvl == NACK ? ST_IGNORE : ST_RDATA;
          addr_d = sda_lvl == ACK ? addr_q + 8'd1 : addr_q;
        end
        default: ;
      endcase
      if (rd_load) begin
        reg_rd_en = 1'b1;
        shift_d = reg_rdata;
        sda_oe_d = ~reg_rdata[I2C_BYTE_W-1];
        cnt_d = 4'd1;
      end
    end
  end
  always_ff @(posedge xtal_clk or negedge por_rst_n) begin
    if (!por_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= 4'd0;
      shift_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wr_en_q <= 1'b0;
      sda_oe_q <= 1'b0;
      idle_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      shift_q <= shift_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wr_en_q <= wr_en_d;
      sda_oe_q <= sda_oe_d;
      idle_q <= idle_d;
    end
  end
  assign sda_oe = sda_oe_q;
  assign reg_addr = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wr_en = wr_en_q;
  assign hif_idle_out = idle_q;
endmodule
